// File: rtl/pc_sequencer.sv
// Fetch-stage program-counter sequencer: increments, holds, redirects through the
// combinational branch-target lookup, or halts; counts taken branches (saturating).
module pc_sequencer #(
  parameter int unsigned PC_W       = 12,
  parameter int unsigned TAG_W      = 8,
  parameter int unsigned START_ADDR = 0,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stall,
  input  logic             halt_req,
  input  logic             br_taken,
  input  logic [TAG_W-1:0] br_tag,
  output logic [TAG_W-1:0] lut_tag,
  input  logic [PC_W-1:0]  lut_target,
  output logic [PC_W-1:0]  prog_ctr,
  output logic             fetch_valid,
  output logic             flush,
  output logic             done,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;
  localparam logic [1:0] HALT  = 2'd3;

  localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

  logic [1:0] state;
  logic [1:0] state_nxt;

  assign lut_tag     = br_tag;
  assign fetch_valid = (state == RUN);
  assign flush       = (state == FLUSH);
  assign done        = (state == HALT);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN: begin
        if (halt_req)      state_nxt = HALT;
        else if (br_taken) state_nxt = FLUSH;
      end
      FLUSH:   state_nxt = halt_req ? HALT : RUN;
      HALT:    if (start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      prog_ctr  <= START_PC;
      taken_cnt <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE, HALT: begin
          if (start) begin
            prog_ctr  <= START_PC;
            taken_cnt <= '0;
          end
        end
        RUN: begin
          // Halt outranks the branch, so a simultaneous branch is dropped uncounted.
          if (halt_req) begin
            prog_ctr <= prog_ctr;
          end else if (br_taken) begin
            prog_ctr <= lut_target;
            if (taken_cnt != '1) taken_cnt <= taken_cnt + 1'b1;
          end else if (!stall) begin
            prog_ctr <= prog_ctr + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (default build plus a CNT_W=4 build).
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, stall, halt_req, br_taken;
  logic [7:0]  br_tag;
  logic [7:0]  lut_tag, lut_tag4;
  logic [11:0] lut_target, lut_target4;
  logic [11:0] prog_ctr, prog_ctr4;
  logic        fetch_valid, flush, done;
  logic        fetch_valid4, flush4, done4;
  logic [15:0] taken_cnt;
  logic [3:0]  taken_cnt4;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  function automatic logic [11:0] lookup(input logic [7:0] tag);
    case (tag)
      8'h03:   lookup = 12'h0A0;
      8'h10:   lookup = 12'hFFE;
      8'h20:   lookup = 12'h010;
      default: lookup = {4'h0, tag};
    endcase
  endfunction

  assign lut_target  = lookup(lut_tag);
  assign lut_target4 = lookup(lut_tag4);

  pc_sequencer #(.PC_W(12), .TAG_W(8), .START_ADDR(0), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall), .halt_req(halt_req),
    .br_taken(br_taken), .br_tag(br_tag), .lut_tag(lut_tag), .lut_target(lut_target),
    .prog_ctr(prog_ctr), .fetch_valid(fetch_valid), .flush(flush), .done(done),
    .taken_cnt(taken_cnt)
  );

  pc_sequencer #(.PC_W(12), .TAG_W(8), .START_ADDR(0), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .start(start), .stall(stall), .halt_req(halt_req),
    .br_taken(br_taken), .br_tag(br_tag), .lut_tag(lut_tag4), .lut_target(lut_target4),
    .prog_ctr(prog_ctr4), .fetch_valid(fetch_valid4), .flush(flush4), .done(done4),
    .taken_cnt(taken_cnt4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; stall = 1'b0; halt_req = 1'b0; br_taken = 1'b0; br_tag = 8'h00;
    tick();
    compared++;
    if (prog_ctr !== 12'h000) begin mismatched++; $display("FAIL reset_pc got=%h exp=000", prog_ctr); end
    compared++;
    if ({fetch_valid, flush, done} !== 3'b000) begin mismatched++; $display("FAIL reset_flags got=%b exp=000", {fetch_valid, flush, done}); end
    compared++;
    if (taken_cnt !== 16'd0) begin mismatched++; $display("FAIL reset_cnt got=%0d exp=0", taken_cnt); end
    reset = 1'b0;
    tick();
    compared++;
    if (fetch_valid !== 1'b0) begin mismatched++; $display("FAIL idle_no_start got=%b exp=0", fetch_valid); end
  endtask

  task automatic test_increment();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      compared++;
      if (prog_ctr !== 12'(i)) begin mismatched++; $display("FAIL inc_pc[%0d] got=%h exp=%h", i, prog_ctr, 12'(i)); end
      compared++;
      if ({fetch_valid, flush, done} !== 3'b100) begin mismatched++; $display("FAIL inc_flags[%0d] got=%b exp=100", i, {fetch_valid, flush, done}); end
      tick();
    end
    compared++;
    if (prog_ctr !== 12'h005) begin mismatched++; $display("FAIL inc_pc5 got=%h exp=005", prog_ctr); end
  endtask

  task automatic test_branch();
    br_taken = 1'b1; br_tag = 8'h03; stall = 1'b1;
    #1;
    compared++;
    if (lut_tag !== 8'h03) begin mismatched++; $display("FAIL lut_tag got=%h exp=03", lut_tag); end
    tick();
    br_taken = 1'b0; stall = 1'b0;
    compared++;
    if (prog_ctr !== 12'h0A0) begin mismatched++; $display("FAIL br_pc got=%h exp=0a0", prog_ctr); end
    compared++;
    if ({fetch_valid, flush} !== 2'b01) begin mismatched++; $display("FAIL br_bubble got=%b exp=01", {fetch_valid, flush}); end
    compared++;
    if (taken_cnt !== 16'd1) begin mismatched++; $display("FAIL br_cnt got=%0d exp=1", taken_cnt); end
    br_taken = 1'b1; br_tag = 8'h20;
    tick();
    br_taken = 1'b0;
    compared++;
    if ({prog_ctr, fetch_valid, flush} !== {12'h0A0, 2'b10}) begin mismatched++; $display("FAIL br_run got=%h/%b exp=0a0/10", prog_ctr, {fetch_valid, flush}); end
    compared++;
    if (taken_cnt !== 16'd1) begin mismatched++; $display("FAIL br_flush_nocount got=%0d exp=1", taken_cnt); end
    tick();
    compared++;
    if (prog_ctr !== 12'h0A1) begin mismatched++; $display("FAIL br_next got=%h exp=0a1", prog_ctr); end
    tick();
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      compared++;
      if ({prog_ctr, fetch_valid} !== {12'h0A2, 1'b1}) begin mismatched++; $display("FAIL stall[%0d] got=%h/%b exp=0a2/1", i, prog_ctr, fetch_valid); end
    end
    stall = 1'b0;
    tick();
    compared++;
    if (prog_ctr !== 12'h0A3) begin mismatched++; $display("FAIL stall_release got=%h exp=0a3", prog_ctr); end
  endtask

  task automatic test_wrap();
    logic [11:0] exp_pc [4];
    exp_pc[0] = 12'hFFE; exp_pc[1] = 12'hFFF; exp_pc[2] = 12'h000; exp_pc[3] = 12'h001;
    br_taken = 1'b1; br_tag = 8'h10;
    tick();
    br_taken = 1'b0;
    compared++;
    if ({prog_ctr, flush} !== {12'hFFE, 1'b1}) begin mismatched++; $display("FAIL wrap_flush got=%h/%b exp=ffe/1", prog_ctr, flush); end
    for (int i = 0; i < 4; i++) begin
      tick();
      compared++;
      if ({prog_ctr, fetch_valid, flush} !== {exp_pc[i], 2'b10}) begin
        mismatched++; $display("FAIL wrap[%0d] got=%h/%b exp=%h/10", i, prog_ctr, {fetch_valid, flush}, exp_pc[i]);
      end
    end
  endtask

  task automatic test_halt_priority();
    br_taken = 1'b1; br_tag = 8'h20;
    tick();
    br_taken = 1'b0;
    tick();
    compared++;
    if ({prog_ctr, taken_cnt} !== {12'h010, 16'd3}) begin mismatched++; $display("FAIL pre_halt got=%h/%0d exp=010/3", prog_ctr, taken_cnt); end
    halt_req = 1'b1; br_taken = 1'b1; br_tag = 8'h03;
    tick();
    halt_req = 1'b0; br_taken = 1'b0;
    for (int i = 0; i < 2; i++) begin
      compared++;
      if ({prog_ctr, fetch_valid, flush, done} !== {12'h010, 3'b001}) begin
        mismatched++; $display("FAIL halt[%0d] got=%h/%b exp=010/001", i, prog_ctr, {fetch_valid, flush, done});
      end
      compared++;
      if (taken_cnt !== 16'd3) begin mismatched++; $display("FAIL halt_cnt[%0d] got=%0d exp=3", i, taken_cnt); end
      tick();
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    compared++;
    if ({prog_ctr, fetch_valid, done, taken_cnt} !== {12'h000, 2'b10, 16'd0}) begin
      mismatched++; $display("FAIL restart got=%h/%b/%0d exp=000/10/0", prog_ctr, {fetch_valid, done}, taken_cnt);
    end
  endtask

  task automatic test_branch_self();
    tick();
    br_taken = 1'b1; br_tag = 8'h01;
    tick();
    br_taken = 1'b0;
    compared++;
    if ({prog_ctr, flush} !== {12'h001, 1'b1}) begin mismatched++; $display("FAIL self_flush got=%h/%b exp=001/1", prog_ctr, flush); end
    tick();
    compared++;
    if ({prog_ctr, fetch_valid} !== {12'h001, 1'b1}) begin mismatched++; $display("FAIL self_run got=%h/%b exp=001/1", prog_ctr, fetch_valid); end
    tick();
    compared++;
    if (prog_ctr !== 12'h002) begin mismatched++; $display("FAIL self_next got=%h exp=002", prog_ctr); end
  endtask

  task automatic test_flush_halt();
    br_taken = 1'b1; br_tag = 8'h03;
    tick();
    br_taken = 1'b0; halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    compared++;
    if ({prog_ctr, done, fetch_valid} !== {12'h0A0, 2'b10}) begin mismatched++; $display("FAIL flush_halt got=%h/%b exp=0a0/10", prog_ctr, {done, fetch_valid}); end
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset_mid_flush();
    tick();
    br_taken = 1'b1; br_tag = 8'h03;
    tick();
    br_taken = 1'b0;
    compared++;
    if (flush !== 1'b1) begin mismatched++; $display("FAIL pre_async flush got=%b exp=1", flush); end
    #2 reset = 1'b1;
    #1;
    compared++;
    if ({prog_ctr, fetch_valid, flush, done, taken_cnt} !== {12'h000, 3'b000, 16'd0}) begin
      mismatched++; $display("FAIL async_reset got=%h/%b/%0d exp=000/000/0", prog_ctr, {fetch_valid, flush, done}, taken_cnt);
    end
    #1 reset = 1'b0;
    tick();
    compared++;
    if (fetch_valid !== 1'b0) begin mismatched++; $display("FAIL post_reset_idle got=%b exp=0", fetch_valid); end
  endtask

  task automatic test_saturation();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      br_taken = 1'b1; br_tag = 8'h03;
      tick();
      br_taken = 1'b0;
      tick();
      if (i == 15 || i == 16 || i == 17) begin
        compared++;
        if (taken_cnt4 !== 4'd15) begin mismatched++; $display("FAIL sat4[%0d] got=%0d exp=15", i, taken_cnt4); end
      end
    end
    compared++;
    if (taken_cnt !== 16'd17) begin mismatched++; $display("FAIL cnt16 got=%0d exp=17", taken_cnt); end
    start = 1'b1;
    tick();
    start = 1'b0;
    compared++;
    if (taken_cnt4 !== 4'd15) begin mismatched++; $display("FAIL start_ignored_run got=%0d exp=15", taken_cnt4); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_increment();
    test_branch();
    test_stall();
    test_wrap();
    test_halt_priority();
    test_branch_self();
    test_flush_halt();
    test_reset_mid_flush();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter sequencer for the fetch stage: owns prog_ctr and decides each cycle whether to increment, hold, redirect or halt.
- Branch redirects go through the existing branch-target lookup. The sequencer drives an 8-bit tag to the lookup and takes back its 12-bit absolute target in the same cycle (the lookup is combinational).
- Sits between the decode/control unit (branch, stall and halt requests) and instruction memory (prog_ctr address).

Parameters:
PC_W, 12, program counter / branch target width
TAG_W, 8, branch lookup tag width
START_ADDR, 0, prog_ctr value after reset and on every start
CNT_W, 16, width of taken-branch counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  begin execution from START_ADDR (honoured in IDLE and HALT only)
stall  input  1  hold prog_ctr this cycle
halt_req  input  1  stop execution
br_taken  input  1  redirect to lookup target this cycle
br_tag  input  TAG_W  branch tag, valid when br_taken=1
lut_tag  output  TAG_W  tag to branch lookup; equals br_tag combinationally
lut_target  input  PC_W  absolute target returned by lookup for lut_tag
prog_ctr  output  PC_W  instruction fetch address (registered)
fetch_valid  output  1  prog_ctr is a live fetch (state RUN)
flush  output  1  redirect bubble; downstream discards the in-flight instruction (state FLUSH)
done  output  1  program halted (state HALT)
taken_cnt  output  CNT_W  number of branches taken since last start, saturating

Behaviour:
- Reset (async, any state, mid-operation included):
  - state=IDLE, prog_ctr=START_ADDR, taken_cnt=0.
  - fetch_valid=0, flush=0, done=0.
- Outputs fetch_valid, flush and done are Moore outputs decoded from state. lut_tag is a pure pass-through of br_tag.
- States: IDLE, RUN, FLUSH, HALT.
- IDLE:
  - start=1 -> RUN; prog_ctr<=START_ADDR; taken_cnt<=0.
  - All other inputs are ignored.
- RUN: fixed priority halt_req > br_taken > stall > increment.
  - halt_req=1 -> HALT; prog_ctr holds.
  - br_taken=1 -> FLUSH.
    - prog_ctr<=lut_target, sampled the same cycle.
    - taken_cnt increments, saturating at 2^CNT_W-1.
    - stall in the same cycle is ignored.
  - stall=1 -> stay RUN; prog_ctr holds.
  - Otherwise prog_ctr<=prog_ctr+1, modulo 2^PC_W (4095 -> 0, no flag).
  - start is ignored in RUN.
- FLUSH: exactly one cycle.
  - halt_req=1 -> HALT.
  - Otherwise -> RUN, with prog_ctr holding the redirected target. The first valid fetch of the target is in the following RUN cycle.
  - br_taken and stall are ignored; br_taken does not count.
- HALT:
  - done=1 and prog_ctr held until start.
  - start=1 -> RUN; prog_ctr<=START_ADDR; taken_cnt<=0.
- Latency:
  - Increment or redirect is visible on prog_ctr one cycle after the request edge.
  - A taken branch costs exactly one bubble cycle (flush=1, fetch_valid=0).
- Branch to the current address (lut_target==prog_ctr) is legal: FLUSH, then RUN at the same address.
- Simultaneous halt_req and br_taken: the halt wins, the branch is dropped and taken_cnt does not change.

Test Plan:
- Reset, then start pulse, 4 idle cycles -> prog_ctr 0,1,2,3,4 across RUN cycles; fetch_valid=1; flush=0; done=0.
- At prog_ctr=5, br_taken=1, br_tag=8'h03, lookup model returns 12'h0A0:
  - cycle+1: prog_ctr=0x0A0, flush=1, fetch_valid=0, taken_cnt=1.
  - cycle+2: RUN, prog_ctr=0x0A0, fetch_valid=1.
  - cycle+3: prog_ctr=0x0A1.
- stall held 3 cycles at prog_ctr=0x0A2 -> prog_ctr stays 0x0A2. The cycle after stall drops, prog_ctr=0x0A3.
- Redirect to 12'hFFE, then run -> prog_ctr FFE, FFF, 000, 001; no glitch on fetch_valid.
- halt_req and br_taken in the same cycle at prog_ctr=0x010 -> HALT, done=1, prog_ctr=0x010, taken_cnt unchanged.
  - Later start -> RUN, prog_ctr=0, taken_cnt=0.
- reset asserted mid-FLUSH (asynchronously, between edges) -> immediately IDLE, prog_ctr=0, all flags 0.
  - Force taken_cnt near max (CNT_W=4 build, 16 branches) -> saturates at 15.
